// File: rtl/s4_sdf_butterfly_pkg.sv
// Shared constants, sample type and half-scale butterfly helpers
// for the FFT stage-4 SDF butterfly.
package s4_sdf_butterfly_pkg;
  localparam int W = 15;
  localparam int FRAC = 14;
  localparam int CNT_W = 5;
  localparam int FRAME_LEN = 8;

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  function automatic logic signed [W-1:0] half_sum(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    return W'(s >>> 1);
  endfunction

  function automatic logic signed [W-1:0] half_dif(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    return W'(s >>> 1);
  endfunction
endpackage

// File: rtl/s4_sdf_butterfly_if.sv
// Sample stream in, butterfly beats plus twiddle index out.
// master drives samples and flush; slave is the butterfly.
interface s4_sdf_butterfly_if;
  import s4_sdf_butterfly_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_real;
  logic signed [W-1:0] in_imag;
  logic                flush;
  logic                out_valid;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_imag;
  logic [CNT_W-1:0]    counter;

  modport master (
    output in_valid, in_real, in_imag, flush,
    input  in_ready, out_valid, out_real, out_imag, counter
  );

  modport slave (
    input  in_valid, in_real, in_imag, flush,
    output in_ready, out_valid, out_real, out_imag, counter
  );
endinterface

// File: rtl/s4_sdf_delay.sv
// Feedback delay line: DEPTH complex words, head is the oldest.
// Shifting moves every word one step toward the head.
module s4_sdf_delay
  import s4_sdf_butterfly_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  shift_i,
  input  cplx_t din_i,
  output cplx_t head_o
);
  cplx_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (shift_i) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      mem_q[DEPTH-1] <= din_i;
    end
  end

  assign head_o = mem_q[0];
endmodule

// File: rtl/s4_sdf_butterfly.sv
// Radix-2 SDF butterfly for FFT stage 4: fill/butterfly phases,
// end-of-stream drain of held differences, registered outputs.
module s4_sdf_butterfly
  import s4_sdf_butterfly_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  s4_sdf_butterfly_if.slave bus
);
  localparam int PH_W = $clog2(2 * DEPTH);
  localparam int CI_W = $clog2(FRAME_LEN);
  localparam int DC_W = $clog2(DEPTH + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * DEPTH - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(DEPTH);
  localparam logic [CI_W-1:0] CI_RST = CI_W'(DEPTH);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEPTH - 1);

  logic [0:0]      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            primed_q, primed_d;
  logic            pend_q, pend_d;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
  logic [CI_W-1:0] nxt_q, nxt_d;
  logic [CI_W-1:0] cnt_q, cnt_d;
  logic            ov_q, ov_d;
  cplx_t           out_q, out_d;

  logic  flush_req, drain_go, in_rdy, accept;
  logic  shift, beat, done;
  cplx_t x, head, push, bval;

  s4_sdf_delay #(.DEPTH(DEPTH)) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_i (shift),
    .din_i   (push),
    .head_o  (head)
  );

  assign x         = '{re: bus.in_real, im: bus.in_imag};
  assign flush_req = bus.flush | pend_q;
  assign drain_go  = (state_q == ST_RUN) & flush_req
                   & (ph_q == '0) & primed_q;
  assign in_rdy    = (state_q == ST_RUN) & ~drain_go;
  assign accept    = bus.in_valid & in_rdy;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    primed_d = primed_q;
    pend_d   = pend_q;
    dcnt_d   = dcnt_q;
    nxt_d    = nxt_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    shift    = 1'b0;
    push     = '0;
    beat     = 1'b0;
    bval     = head;
    done     = 1'b0;

    if (state_q == ST_RUN) begin
      pend_d = pend_q | bus.flush;
      if (flush_req && ph_q == '0 && !primed_q) pend_d = 1'b0;
      if (drain_go) begin
        shift = 1'b1;
        beat  = 1'b1;
        if (DEPTH == 1) begin
          done = 1'b1;
        end else begin
          state_d = ST_DRAIN;
          dcnt_d  = DC_W'(1);
        end
      end else if (accept) begin
        shift = 1'b1;
        ph_d  = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
        if (ph_q < PH_HALF) begin
          push = x;
          beat = primed_q;
        end else begin
          push = '{re: half_dif(head.re, x.re),
                   im: half_dif(head.im, x.im)};
          bval = '{re: half_sum(head.re, x.re),
                   im: half_sum(head.im, x.im)};
          beat = 1'b1;
          if (ph_q == PH_LAST) primed_d = 1'b1;
        end
      end
    end else begin
      shift  = 1'b1;
      beat   = 1'b1;
      dcnt_d = dcnt_q + DC_W'(1);
      if (dcnt_q == DC_LAST) done = 1'b1;
    end

    if (beat) begin
      out_d = bval;
      cnt_d = nxt_q;
      nxt_d = nxt_q + CI_W'(1);
    end else if (state_q == ST_RUN && !primed_q && ph_q == '0) begin
      cnt_d = CI_RST;
    end

    // Stream ended: next stream restarts at the first sum index.
    if (done) begin
      state_d  = ST_RUN;
      ph_d     = '0;
      primed_d = 1'b0;
      pend_d   = 1'b0;
      nxt_d    = CI_RST;
    end

    ov_d = beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      ph_q     <= '0;
      primed_q <= 1'b0;
      pend_q   <= 1'b0;
      dcnt_q   <= '0;
      nxt_q    <= CI_RST;
      cnt_q    <= CI_RST;
      ov_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      primed_q <= primed_d;
      pend_q   <= pend_d;
      dcnt_q   <= dcnt_d;
      nxt_q    <= nxt_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      out_q    <= out_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov_q;
  assign bus.out_real  = out_q.re;
  assign bus.out_imag  = out_q.im;
  assign bus.counter   = CNT_W'(cnt_q);
endmodule

// File: tb/tb_s4_sdf_butterfly.sv
// Scoreboard bench for s4_sdf_butterfly: frame-level reference model,
// expected beats queued per cycle and checked by a separate monitor.
module tb_s4_sdf_butterfly;
  import s4_sdf_butterfly_pkg::*;

  localparam int D = 2;

  typedef struct {
    int re;
    int im;
    int cnt;
  } beat_t;

  typedef struct {
    int re;
    int im;
  } smp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lowcnt = 0;

  beat_t expq[$];
  smp_t  aq[$];
  smp_t  dq[$];
  int    m_n, m_idx, m_drain;
  bit    m_pend;

  s4_sdf_butterfly_if bus ();

  s4_sdf_butterfly #(.DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: unexpected out_valid re=%0d",
                   $signed(bus.out_real));
        end else begin
          beat_t e;
          e = expq.pop_front();
          checks++;
          if ($signed(bus.out_real) != e.re ||
              $signed(bus.out_imag) != e.im ||
              int'(bus.counter) != e.cnt) begin
            errors++;
            $display("FAIL beat: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                     $signed(bus.out_real), $signed(bus.out_imag),
                     bus.counter, e.re, e.im, e.cnt);
          end
        end
      end else if (expq.size() != 0) begin
        beat_t e;
        e = expq.pop_front();
        checks++;
        errors++;
        $display("FAIL beat: got none expected (%0d,%0d,c%0d)",
                 e.re, e.im, e.cnt);
      end
    end
  end

  function automatic void model_reset();
    expq.delete();
    aq.delete();
    dq.delete();
    m_n = 0;
    m_idx = D;
    m_drain = 0;
    m_pend = 1'b0;
  endfunction

  function automatic void expect_beat(input int re, input int im);
    expq.push_back('{re: re, im: im, cnt: m_idx});
    m_idx = (m_idx + 1) % 8;
  endfunction

  function automatic void emit_diff();
    smp_t s;
    s = dq.pop_front();
    expect_beat(s.re, s.im);
  endfunction

  // One clock: drive inputs, advance the reference model, check in_ready.
  task automatic cyc(input bit v, input int re, input int im,
                     input bit fl, output bit acc);
    bit rdy;
    bit freq;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_real  = W'(re);
    bus.in_imag  = W'(im);
    bus.flush    = fl;
    #1;
    acc  = 1'b0;
    rdy  = 1'b1;
    freq = fl || m_pend;
    if (m_drain > 0) begin
      rdy = 1'b0;
      emit_diff();
      m_drain--;
      if (m_drain == 0) begin m_pend = 1'b0; m_idx = D; end
    end else if (freq && m_n == 0 && dq.size() > 0) begin
      rdy = 1'b0;
      m_pend = 1'b1;
      emit_diff();
      m_drain = D - 1;
      if (m_drain == 0) begin m_pend = 1'b0; m_idx = D; end
    end else begin
      m_pend = freq && (m_n != 0);
      if (v) begin
        acc = 1'b1;
        if (m_n < D) begin
          aq.push_back('{re: re, im: im});
          if (dq.size() > 0) emit_diff();
        end else begin
          smp_t a;
          a = aq.pop_front();
          expect_beat((a.re + re) >>> 1, (a.im + im) >>> 1);
          dq.push_back('{re: (a.re - re) >>> 1, im: (a.im - im) >>> 1});
        end
        m_n = (m_n + 1) % (2 * D);
      end
    end
    if (!bus.in_ready) lowcnt++;
    chk("in_ready", int'(bus.in_ready), int'(rdy));
  endtask

  task automatic idle();
    bit a;
    cyc(1'b0, 0, 0, 1'b0, a);
  endtask

  task automatic send(input int re, input int im);
    bit a;
    int k;
    a = 1'b0;
    for (k = 0; k < 20 && !a; k++) cyc(1'b1, re, im, 1'b0, a);
    if (!a) chk("send_timeout", 0, 1);
  endtask

  task automatic do_flush();
    bit a;
    lowcnt = 0;
    cyc(1'b0, 0, 0, 1'b1, a);
    for (int k = 0; k < 20 && m_drain > 0; k++) idle();
    if (m_drain > 0) chk("drain_timeout", 0, 1);
    idle();
    idle();
    chk("ready_low_cycles", lowcnt, D);
    chk("counter_after_drain", int'(bus.counter), D);
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 32767)) - 16384;
  endfunction

  initial begin
    bit a;
    bus.in_valid = 1'b0;
    bus.in_real  = '0;
    bus.in_imag  = '0;
    bus.flush    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_real", int'(bus.out_real), 0);
    chk("rst_out_imag", int'(bus.out_imag), 0);
    chk("rst_counter", int'(bus.counter), D);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;

    send(4096, 0);
    send(2048, 0);
    send(1024, 0);
    send(512, 0);
    do_flush();

    for (int i = 0; i < 8; i++) send(i, 0);
    do_flush();

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      send(rnd(), rnd());
    end
    do_flush();

    send(-16384, -16384);
    send(16383, 5);
    send(-16384, -16384);
    send(-16384, -7);
    do_flush();

    for (int i = 0; i < 5; i++) send(rnd(), rnd());
    cyc(1'b0, 0, 0, 1'b1, a);
    for (int i = 0; i < 3; i++) send(rnd(), rnd());
    for (int i = 0; i < 4; i++) send(rnd(), rnd());
    do_flush();

    for (int i = 0; i < 4; i++) send(rnd(), rnd());
    cyc(1'b0, 0, 0, 1'b1, a);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    model_reset();
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_real", int'(bus.out_real), 0);
    chk("midrst_out_imag", int'(bus.out_imag), 0);
    chk("midrst_counter", int'(bus.counter), D);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) send(rnd(), rnd());
    do_flush();
    idle();
    chk("queue_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
